// File: rtl/disp_pkg.sv
// Shared constants and types for the 7-segment display path.
// Anode polarity lives here so the decoder top level agrees with the scanner.
package disp_pkg;
    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Common-anode display: a low anode enables the digit
    localparam logic ANODE_ON  = 1'b0;
    localparam logic ANODE_OFF = 1'b1;
endpackage

// File: rtl/display_scan_if.sv
// Bus between the result register, the scanner and the segment decoder.
// The master side supplies the value, the slave side drives the digit outputs.
interface display_scan_if #(
    parameter int N_DIGITS = 4
);
    import disp_pkg::*;

    localparam int DW = $clog2(N_DIGITS);

    logic [NIBBLE_W*N_DIGITS-1:0] data_i;
    logic                         load_i;
    logic                         blank_lz_i;
    nibble_t                      s_muxfue;
    logic [N_DIGITS-1:0]          an_o;
    logic [DW-1:0]                digit_o;
    logic                         pending_o;

    modport master (
        output data_i, load_i, blank_lz_i,
        input  s_muxfue, an_o, digit_o, pending_o
    );

    modport slave (
        input  data_i, load_i, blank_lz_i,
        output s_muxfue, an_o, digit_o, pending_o
    );
endinterface

// File: rtl/display_scan_prescaler.sv
// Divide-by-DIV free-running counter with a one-cycle terminal tick.
// Also used for other display and debounce timing.
module scan_prescaler #(
    parameter int DIV = 27000,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic          tick
);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign tick = (cnt == LAST);

    // Count 0..DIV-1 and wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/display_scan.sv
// Time-multiplexed N-digit hex scanner with leading-zero blanking.
// New values are held pending and only swapped in at a slot boundary.
module display_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 27000,
    parameter int GUARD_CYCLES = 16
) (
    input logic           clk,
    input logic           rst,
    display_scan_if.slave bus
);
    localparam int DW = $clog2(N_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int VW = NIBBLE_W * N_DIGITS;

    localparam logic [DW-1:0] LAST_DIG = DW'(N_DIGITS - 1);
    localparam logic [CW-1:0] GUARD    = CW'(GUARD_CYCLES);

    logic [CW-1:0]       cnt;
    logic                tick;
    logic [DW-1:0]       digit;
    logic [VW-1:0]       pend_val;
    logic [VW-1:0]       shown;
    logic                pend;
    logic [N_DIGITS-1:0] blanked;
    logic                hi_zero;
    logic                lit;

    scan_prescaler #(
        .DIV (REFRESH_DIV),
        .CW  (CW)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .tick (tick)
    );

    assign bus.digit_o   = digit;
    assign bus.pending_o = pend;

    // Digit k>0 is blank when it and every digit above it is zero
    always_comb begin
        hi_zero = 1'b1;
        blanked = '0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            hi_zero    = hi_zero & (shown[k*NIBBLE_W +: NIBBLE_W] == '0);
            blanked[k] = hi_zero & bus.blank_lz_i;
        end
    end

    assign lit = (cnt >= GUARD) && !blanked[digit];

    // Advance the digit index once per slot
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (tick) begin
            digit <= (digit == LAST_DIG) ? '0 : digit + 1'b1;
        end
    end

    // Pending/shown registers; commit uses the value held before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val <= '0;
            shown    <= '0;
            pend     <= 1'b0;
        end else begin
            if (tick && pend) begin
                shown <= pend_val;
                pend  <= 1'b0;
            end
            if (bus.load_i) begin
                pend_val <= bus.data_i;
                pend     <= 1'b1;
            end
        end
    end

    // Registered digit nibble and anode enables
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s_muxfue <= '0;
            bus.an_o     <= {N_DIGITS{ANODE_OFF}};
        end else begin
            bus.s_muxfue <= shown[int'(digit)*NIBBLE_W +: NIBBLE_W];
            bus.an_o     <= {N_DIGITS{ANODE_OFF}};
            if (lit) begin
                bus.an_o[digit] <= ANODE_ON;
            end
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// Randomized and directed bench for display_scan against a slot-level model.
// Expected outputs come from elapsed-cycle arithmetic and value shifts.
module tb_display_scan;
    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int GRD = 2;

    logic clk;
    logic rst;
    int   errs;
    int   nchk;

    // Reference model state
    int          mt;
    logic [15:0] m_shown;
    logic [15:0] m_pend;
    logic        m_pv;
    logic [3:0]  m_mux;
    logic [3:0]  m_an;

    display_scan_if #(.N_DIGITS(N)) bus();

    display_scan #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (DIV),
        .GUARD_CYCLES (GRD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s t=%0d got=%h want=%h",
                     tag, mt, obs, exp);
        end
    endtask

    function automatic int m_cnt();
        return mt % DIV;
    endfunction

    function automatic int m_dig();
        return (mt / DIV) % N;
    endfunction

    // One clock: drive inputs, predict, clock, compare everything
    task automatic step(input logic r, input logic ld,
                        input logic [15:0] d, input logic bz);
        int          c;
        int          g;
        logic [15:0] upper;
        logic        is_lit;
        rst            = r;
        bus.load_i     = ld;
        bus.data_i     = d;
        bus.blank_lz_i = bz;
        if (r) begin
            mt      = 0;
            m_shown = '0;
            m_pend  = '0;
            m_pv    = 1'b0;
            m_mux   = '0;
            m_an    = 4'hF;
        end else begin
            c      = m_cnt();
            g      = m_dig();
            upper  = m_shown >> (4 * g);
            m_mux  = upper[3:0];
            is_lit = (c >= GRD) && !(bz && g > 0 && upper == 0);
            m_an   = is_lit ? ~(4'b0001 << g) : 4'hF;
            if (c == DIV - 1 && m_pv) begin
                m_shown = m_pend;
                m_pv    = 1'b0;
            end
            if (ld) begin
                m_pend = d;
                m_pv   = 1'b1;
            end
            mt++;
        end
        @(posedge clk);
        #1;
        check("an", 32'(bus.an_o), 32'(m_an));
        check("mux", 32'(bus.s_muxfue), 32'(m_mux));
        check("dig", 32'(bus.digit_o), 32'(m_dig()));
        check("pend", 32'(bus.pending_o), 32'(m_pv));
    endtask

    task automatic idle(input int n, input logic bz);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, bz);
    endtask

    // Idle until the model sits at the given digit and count
    task automatic wait_at(input int dg, input int ct, input logic bz);
        int budget;
        budget = 200;
        while (!(m_dig() == dg && m_cnt() == ct) && budget > 0) begin
            step(1'b0, 1'b0, 16'h0, bz);
            budget--;
        end
        check("wait_ok", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        errs           = 0;
        nchk           = 0;
        mt             = 0;
        rst            = 1'b1;
        bus.load_i     = 1'b0;
        bus.data_i     = '0;
        bus.blank_lz_i = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        check("rst_an", 32'(bus.an_o), 32'hF);
        check("rst_mux", 32'(bus.s_muxfue), 32'h0);

        idle(3, 1'b0);
        check("an_rel", 32'(bus.an_o), 32'hE);

        step(1'b0, 1'b1, 16'h12A4, 1'b0);
        idle(5 * DIV, 1'b0);

        step(1'b0, 1'b1, 16'h0050, 1'b1);
        idle(5 * DIV, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(5 * DIV, 1'b1);

        wait_at(1, 3, 1'b0);
        step(1'b0, 1'b1, 16'h1111, 1'b0);
        idle(5 * DIV, 1'b0);

        wait_at(0, 2, 1'b0);
        step(1'b0, 1'b1, 16'h0001, 1'b0);
        wait_at(0, DIV - 1, 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        idle(3 * DIV, 1'b0);

        begin
            logic bz;
            bz = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) bz = ~bz;
                step(1'b0, ($urandom_range(0, 7) == 0),
                     16'($urandom), bz);
            end
        end

        step(1'b0, 1'b1, 16'h9876, 1'b0);
        wait_at(2, 5, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        check("mid_an", 32'(bus.an_o), 32'hF);
        check("mid_dig", 32'(bus.digit_o), 32'h0);
        idle(5 * DIV, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
